// File: rtl/modulo_controlador_jogo.sv
// Naval-battle sequencer: debounced confirm button, CLEAR/POSITION/ATTACK/END flow, scoring.
// Optional feature SHOT_LIMIT_EN: a game is lost when MAX_SHOTS shots are taken without sinking the ship.
//
//  state | meaning
//  IDLE  | waiting for POSITION mode, or ATTACK once a ship is placed
//  POS   | accepting ship-cell placements
//  ATK   | accepting shots; board locked
//  END   | game finished; only CLEAR leaves
module modulo_controlador_jogo #(
    parameter int DEB_CYCLES = 250000,
    parameter int SHIP_CELLS = 3,
    parameter int MAX_SHOTS  = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn,
    input  logic [1:0] mode,
    input  logic [5:0] coord,
    input  logic       hit_in,
    input  logic       at_done,
    output logic       po_load,
    output logic       at_write,
    output logic       mtx_clr,
    output logic       err,
    output logic [1:0] state,
    output logic [3:0] hits,
    output logic [4:0] shots,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_POS  = 2'b01,
        S_ATK  = 2'b10,
        S_END  = 2'b11
    } state_t;

    localparam logic [1:0] M_CLEAR = 2'b00;
    localparam logic [1:0] M_ATK   = 2'b01;
    localparam logic [1:0] M_POS   = 2'b10;

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES - 1);
    localparam logic [3:0] SHIP_L = 4'(SHIP_CELLS);
    localparam logic [4:0] MAX_L  = 5'(MAX_SHOTS);

`ifdef SHOT_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    state_t        st;
    logic          placed;
    logic          btn_m, btn_s;
    logic          level, level_d;
    logic [CW-1:0] deb_cnt;
    logic          press;
    logic          valid;

    assign state = st;
    assign press = level & ~level_d;
    assign valid = (coord[5:3] <= 3'd6) && (coord[2:0] <= 3'd4);

    // Down-counter reloads whenever the synced input agrees with the adopted level,
    // so any bounce back restarts the stability window.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_m   <= btn;
            btn_s   <= btn_m;
            level_d <= level;
            if (btn_s == level) begin
                deb_cnt <= DEB_LOAD;
            end else if (deb_cnt == '0) begin
                level   <= btn_s;
                deb_cnt <= DEB_LOAD;
            end else begin
                deb_cnt <= deb_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st        <= S_IDLE;
            placed    <= 1'b0;
            po_load   <= 1'b0;
            at_write  <= 1'b0;
            mtx_clr   <= 1'b0;
            err       <= 1'b0;
            hits      <= '0;
            shots     <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            po_load  <= 1'b0;
            at_write <= 1'b0;
            err      <= 1'b0;
            mtx_clr  <= 1'b0;
            if (mode == M_CLEAR) begin
                st        <= S_IDLE;
                placed    <= 1'b0;
                hits      <= '0;
                shots     <= '0;
                game_over <= 1'b0;
                win       <= 1'b0;
                mtx_clr   <= 1'b1;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (mode == M_POS)
                            st <= S_POS;
                        else if (mode == M_ATK && placed)
                            st <= S_ATK;
                    end
                    S_POS: begin
                        if (press && !valid) begin
                            err <= 1'b1;
                        end else if (press && mode == M_POS) begin
                            po_load <= 1'b1;
                            placed  <= 1'b1;
                        end
                        if (mode == M_ATK && placed)
                            st <= S_ATK;
                    end
                    S_ATK: begin
                        // End checks run on counters already updated by the previous strobe.
                        if (hits == SHIP_L) begin
                            st        <= S_END;
                            game_over <= 1'b1;
                            win       <= 1'b1;
                        end else if (LIM_EN && shots == MAX_L) begin
                            st        <= S_END;
                            game_over <= 1'b1;
                        end else if (press && mode == M_ATK) begin
                            if (valid && !at_done) begin
                                at_write <= 1'b1;
                                if (shots != 5'h1F)
                                    shots <= shots + 5'd1;
                                if (hit_in && hits != 4'hF)
                                    hits <= hits + 4'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_END: begin
                        st <= S_END;
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modulo_controlador_jogo.sv
// Directed bench for modulo_controlador_jogo with a short debounce window (DEB_CYCLES=4).
module tb_modulo_controlador_jogo;

    logic       clk = 1'b0;
    logic       clr, btn, hit_in, at_done;
    logic [1:0] mode;
    logic [5:0] coord;
    logic       po_load, at_write, mtx_clr, err, game_over, win;
    logic [1:0] state;
    logic [3:0] hits;
    logic [4:0] shots;

    int n_checks = 0;
    int n_fail   = 0;

    modulo_controlador_jogo #(
        .DEB_CYCLES(4),
        .SHIP_CELLS(3),
        .MAX_SHOTS (20)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn      (btn),
        .mode     (mode),
        .coord    (coord),
        .hit_in   (hit_in),
        .at_done  (at_done),
        .po_load  (po_load),
        .at_write (at_write),
        .mtx_clr  (mtx_clr),
        .err      (err),
        .state    (state),
        .hits     (hits),
        .shots    (shots),
        .game_over(game_over),
        .win      (win)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Holds btn for 8 clocks then releases for 12, counting high cycles of each pulse output.
    task automatic do_press(output int n_po, output int n_aw, output int n_err, output int n_pr);
        n_po = 0; n_aw = 0; n_err = 0; n_pr = 0;
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_po  += int'(po_load);
            n_aw  += int'(at_write);
            n_err += int'(err);
            n_pr  += int'(dut.press);
            if (i == 7) btn = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [5:0] coord;
        logic       hit_in;
        logic       at_done;
        int         e_aw;
        int         e_err;
        int         e_hits;
        int         e_shots;
        int         e_state;
        int         e_win;
        int         e_go;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int po, aw, er, pr, tot_aw;

        vecs = '{
            '{2'b01, 6'b111_000, 1'b0, 1'b0, 0, 1, 0, 0, 2, 0, 0},
            '{2'b01, 6'b001_010, 1'b1, 1'b0, 1, 0, 1, 1, 2, 0, 0},
            '{2'b01, 6'b001_010, 1'b1, 1'b1, 0, 1, 1, 1, 2, 0, 0},
            '{2'b01, 6'b000_101, 1'b1, 1'b0, 0, 1, 1, 1, 2, 0, 0},
            '{2'b01, 6'b110_100, 1'b0, 1'b0, 1, 0, 1, 2, 2, 0, 0},
            '{2'b01, 6'b000_000, 1'b1, 1'b0, 1, 0, 2, 3, 2, 0, 0},
            '{2'b10, 6'b011_011, 1'b1, 1'b0, 0, 0, 2, 3, 2, 0, 0},
            '{2'b01, 6'b011_011, 1'b1, 1'b0, 1, 0, 3, 4, 3, 1, 1},
            '{2'b01, 6'b100_000, 1'b1, 1'b0, 0, 0, 3, 4, 3, 1, 1}
        };

        clr = 1'b1; btn = 1'b0; mode = 2'b11; coord = '0; hit_in = 1'b0; at_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_hits", hits, 0);
        check("rst_shots", shots, 0);
        check("rst_po_load", po_load, 0);
        check("rst_at_write", at_write, 0);
        check("rst_err", err, 0);
        check("rst_mtx_clr", mtx_clr, 0);
        check("rst_win", win, 0);
        check("rst_game_over", game_over, 0);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // 3-cycle glitch must not produce a press
        pr = 0;
        btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pr += int'(dut.press);
            if (i == 2) btn = 1'b0;
        end
        check("glitch_press", pr, 0);

        do_press(po, aw, er, pr);
        check("long_press_count", pr, 1);
        check("idle_press_no_err", er, 0);
        check("idle_state", state, 0);

        mode = 2'b10;
        @(negedge clk);
        check("pos_entry", state, 1);
        coord = 6'b010_011;
        do_press(po, aw, er, pr);
        check("pos_po_load", po, 1);
        check("pos_no_err", er, 0);

        mode = 2'b01;
        @(negedge clk);
        check("atk_entry", state, 2);

        for (int v = 0; v < 9; v++) begin
            mode = vecs[v].mode; coord = vecs[v].coord;
            hit_in = vecs[v].hit_in; at_done = vecs[v].at_done;
            do_press(po, aw, er, pr);
            check($sformatf("vec%0d_at_write", v), aw, vecs[v].e_aw);
            check($sformatf("vec%0d_err", v), er, vecs[v].e_err);
            check($sformatf("vec%0d_po_load", v), po, 0);
            check($sformatf("vec%0d_hits", v), hits, vecs[v].e_hits);
            check($sformatf("vec%0d_shots", v), shots, vecs[v].e_shots);
            check($sformatf("vec%0d_state", v), state, vecs[v].e_state);
            check($sformatf("vec%0d_win", v), win, vecs[v].e_win);
            check($sformatf("vec%0d_game_over", v), game_over, vecs[v].e_go);
        end

        mode = 2'b00; hit_in = 1'b0; at_done = 1'b0;
        @(negedge clk);
        check("clear_state", state, 0);
        check("clear_hits", hits, 0);
        check("clear_shots", shots, 0);
        check("clear_mtx_clr", mtx_clr, 1);
        check("clear_game_over", game_over, 0);
        check("clear_win", win, 0);

        // miss-only game
        mode = 2'b10;
        @(negedge clk);
        coord = 6'b000_000;
        do_press(po, aw, er, pr);
        mode = 2'b01;
        @(negedge clk);
        check("miss_atk_entry", state, 2);
        tot_aw = 0;
`ifdef SHOT_LIMIT_EN
        for (int k = 0; k < 20; k++) begin
            coord = {3'(k % 7), 3'(k % 5)};
            do_press(po, aw, er, pr);
            tot_aw += aw;
        end
        check("limit_strobes", tot_aw, 20);
        check("limit_state", state, 3);
        check("limit_win", win, 0);
        check("limit_game_over", game_over, 1);
        check("limit_shots", shots, 20);
`else
        for (int k = 0; k < 40; k++) begin
            coord = {3'(k % 7), 3'(k % 5)};
            do_press(po, aw, er, pr);
            tot_aw += aw;
        end
        check("nolimit_strobes", tot_aw, 40);
        check("nolimit_state", state, 2);
        check("nolimit_shots", shots, 31);
        check("nolimit_game_over", game_over, 0);
`endif

        // asynchronous clear in the middle of an attack
        mode = 2'b00;
        @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        coord = 6'b000_000;
        do_press(po, aw, er, pr);
        mode = 2'b01;
        @(negedge clk);
        hit_in = 1'b1;
        coord = 6'b001_001;
        do_press(po, aw, er, pr);
        coord = 6'b010_010;
        do_press(po, aw, er, pr);
        check("pre_clr_hits", hits, 2);
        clr = 1'b1;
        #1;
        check("clr_async_state", state, 0);
        check("clr_async_hits", hits, 0);
        check("clr_async_shots", shots, 0);
        check("clr_async_at_write", at_write, 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_unplaced_idle", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
